// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out shift register with frame assembly.
// Collects WIDTH qualified serial bits in MSB- or LSB-first order. Each
// completed word is published through a one-entry valid/ready buffer, and a
// sticky overrun flag records any completed word that had to be dropped.
module sipo_frame_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d,
  input  logic                     shift,
  input  logic                     load,
  input  logic [WIDTH-1:0]         pdata,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic [WIDTH-1:0]         frame,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Output buffer state: EMPTY means no unconsumed word, FULL means frame is valid.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [0:0]       state_q, state_d;
  logic             overrun_q, overrun_d;

  logic             shift_en_s;
  logic [WIDTH-1:0] shifted_s;
  logic             complete_s;
  logic             xfer_s;

  // Shift-register datapath and bit counter; load wins over shift.
  always_comb begin
    shift_en_s = !load && shift;
    if (MSB_FIRST) begin
      shifted_s = {q_q[WIDTH-2:0], d};
    end else begin
      shifted_s = {d, q_q[WIDTH-1:1]};
    end
    // A frame completes only on the shift that consumes the last bit slot.
    complete_s = shift_en_s && (count_q == LAST_CNT);

    q_d     = q_q;
    count_d = count_q;
    if (load) begin
      q_d     = pdata;
      count_d = {CW{1'b0}};
    end else if (shift_en_s) begin
      q_d = shifted_s;
      if (count_q == LAST_CNT) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + CW'(1);
      end
    end else begin
      q_d     = q_q;
      count_d = count_q;
    end
  end

  // One-entry output buffer: capture, hand off, or drop with overrun.
  always_comb begin
    xfer_s    = (state_q == ST_FULL) && frame_ready;
    state_d   = state_q;
    frame_d   = frame_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete_s) begin
          state_d = ST_FULL;
          frame_d = shifted_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (complete_s && xfer_s) begin
          // Consumer drains the old word on the same edge the new one lands.
          frame_d = shifted_s;
        end else if (complete_s) begin
          overrun_d = 1'b1;
        end else if (xfer_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State registers with synchronous reset that discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= {WIDTH{1'b0}};
      count_q   <= {CW{1'b0}};
      frame_q   <= {WIDTH{1'b0}};
      state_q   <= ST_EMPTY;
      overrun_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      count_q   <= count_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  assign q           = q_q;
  assign count       = count_q;
  assign frame       = frame_q;
  assign frame_valid = (state_q == ST_FULL);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: one MSB-first and one LSB-first instance (WIDTH=4)
// share a stimulus stream; a word-level reference model predicts every output.
module tb_sipo_frame_rx;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         d;
  logic         shift;
  logic         load;
  logic [W-1:0] pdata;
  logic         frame_ready;

  logic [W-1:0] q_m, frame_m, q_l, frame_l;
  logic [1:0]   count_m, count_l;
  logic         fv_m, fv_l, ov_m, ov_l;

  int n_cmp;
  int n_mis;

  // Reference model state
  int m_qm, m_ql, m_fm, m_fl, m_cnt;
  bit m_fv, m_ov;

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .d(d), .shift(shift), .load(load), .pdata(pdata),
    .q(q_m), .count(count_m), .frame(frame_m), .frame_valid(fv_m),
    .frame_ready(frame_ready), .overrun(ov_m)
  );

  sipo_frame_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .shift(shift), .load(load), .pdata(pdata),
    .q(q_l), .count(count_l), .frame(frame_l), .frame_valid(fv_l),
    .frame_ready(frame_ready), .overrun(ov_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    bit xfer;
    bit comp;
    xfer = m_fv && frame_ready;
    comp = 1'b0;
    if (rst) begin
      m_qm = 0; m_ql = 0; m_fm = 0; m_fl = 0; m_cnt = 0; m_fv = 1'b0; m_ov = 1'b0;
    end else begin
      if (load) begin
        m_qm  = int'(pdata);
        m_ql  = int'(pdata);
        m_cnt = 0;
      end else if (shift) begin
        m_qm  = ((m_qm << 1) | int'(d)) & MASK;
        m_ql  = (m_ql >> 1) | (int'(d) << (W - 1));
        m_cnt = m_cnt + 1;
        if (m_cnt == W) begin
          m_cnt = 0;
          comp  = 1'b1;
        end
      end
      if (comp && (!m_fv || xfer)) begin
        m_fm = m_qm;
        m_fl = m_ql;
        m_fv = 1'b1;
      end else if (comp) begin
        m_ov = 1'b1;
      end else if (xfer) begin
        m_fv = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("q_msb",      32'(q_m),     32'(m_qm));
    chk("q_lsb",      32'(q_l),     32'(m_ql));
    chk("count_msb",  32'(count_m), 32'(m_cnt));
    chk("count_lsb",  32'(count_l), 32'(m_cnt));
    chk("frame_msb",  32'(frame_m), 32'(m_fm));
    chk("frame_lsb",  32'(frame_l), 32'(m_fl));
    chk("fvalid_msb", 32'(fv_m),    32'(m_fv));
    chk("fvalid_lsb", 32'(fv_l),    32'(m_fv));
    chk("overrun_msb", 32'(ov_m),   32'(m_ov));
    chk("overrun_lsb", 32'(ov_l),   32'(m_ov));
  endtask

  task automatic step(input logic r, input logic dd, input logic sh, input logic ld,
                      input logic [W-1:0] pd, input logic rdy);
    @(negedge clk);
    rst = r; d = dd; shift = sh; load = ld; pdata = pd; frame_ready = rdy;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_qm = 0; m_ql = 0; m_fm = 0; m_fl = 0; m_cnt = 0; m_fv = 1'b0; m_ov = 1'b0;
    rst = 1'b1; d = 1'b0; shift = 1'b0; load = 1'b0; pdata = 4'h0; frame_ready = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    chk("rst_q", 32'(q_m), 32'h0);
    chk("rst_fv", 32'(fv_m), 32'h0);

    // Test 1/2: stream 1,0,1,1 with consumer stalled
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t1_fv_before_last", 32'(fv_m), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t1_q_msb", 32'(q_m), 32'hB);
    chk("t1_frame_msb", 32'(frame_m), 32'hB);
    chk("t1_fv", 32'(fv_m), 32'h1);
    chk("t1_count", 32'(count_m), 32'h0);
    chk("t2_q_lsb", 32'(q_l), 32'hD);
    chk("t2_frame_lsb", 32'(frame_l), 32'hD);

    // Test 3: second frame 0,0,0,1 while stalled -> dropped, overrun
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t3_frame_msb", 32'(frame_m), 32'hB);
    chk("t3_overrun", 32'(ov_m), 32'h1);
    chk("t3_q_msb", 32'(q_m), 32'h1);

    // Test 4: fill buffer, then transfer on the completing edge of 0,1,1,0
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("t4_frame_msb", 32'(frame_m), 32'h6);
    chk("t4_fv", 32'(fv_m), 32'h1);
    chk("t4_overrun", 32'(ov_m), 32'h0);

    // Test 5: partial frame abandoned by load
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0);
    chk("t5_q_msb", 32'(q_m), 32'hA);
    chk("t5_q_lsb", 32'(q_l), 32'hA);
    chk("t5_count", 32'(count_m), 32'h0);
    chk("t5_fv", 32'(fv_m), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
    chk("t5_drained", 32'(fv_m), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t5_frame_msb", 32'(frame_m), 32'h0);
    chk("t5_fv_after", 32'(fv_m), 32'h1);

    // Test 6: force overrun, then reset mid-frame after 3 shifts
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t6_overrun_set", 32'(ov_m), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t6_rst_q", 32'(q_m), 32'h0);
    chk("t6_rst_count", 32'(count_m), 32'h0);
    chk("t6_rst_fv", 32'(fv_m), 32'h0);
    chk("t6_rst_ov", 32'(ov_m), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("t6_frame_msb", 32'(frame_m), 32'hC);
    chk("t6_frame_lsb", 32'(frame_l), 32'h3);
    chk("t6_fv", 32'(fv_m), 32'h1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 29) == 0),
           4'($urandom),
           1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
